// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : round-robin share of one memory port between fetch and LSU
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              if_req_valid_i,
  output logic              if_req_ready_o,
  input  logic [31:0]       if_req_addr_i,
  output logic              if_rsp_valid_o,
  output logic [31:0]       if_rsp_data_o,
  input  logic              d_req_valid_i,
  output logic              d_req_ready_o,
  input  logic [31:0]       d_req_addr_i,
  input  logic              d_req_we_i,
  input  logic [31:0]       d_req_wdata_i,
  input  logic [3:0]        d_req_wstrb_i,
  output logic              d_rsp_valid_o,
  output logic [31:0]       d_rsp_data_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  localparam int              CNT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);
  localparam logic            OWN_FETCH = 1'b0;
  localparam logic            OWN_DATA  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               owner_q, owner_d;

  logic               win_if;
  logic               win_d;
  logic [31:0]        rsp_data;

  // On a tie the requester that was not served last wins.
  assign win_if = !reset_i && if_req_valid_i && (!d_req_valid_i || (last_q == OWN_DATA));
  assign win_d  = !reset_i && d_req_valid_i  && (!if_req_valid_i || (last_q == OWN_FETCH));
  assign busy_o = (state_q != S_IDLE);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_addr_i[31:ADDR_W+2], if_req_addr_i[1:0],
                              d_req_addr_i[31:ADDR_W+2], d_req_addr_i[1:0]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      last_q  <= OWN_DATA;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      owner_q <= OWN_FETCH;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    owner_d        = owner_q;
    if_req_ready_o = 1'b0;
    d_req_ready_o  = 1'b0;
    if_rsp_valid_o = 1'b0;
    if_rsp_data_o  = '0;
    d_rsp_valid_o  = 1'b0;
    d_rsp_data_o   = '0;
    mem_en_o       = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    mem_wstrb_o    = '0;
    rsp_data       = '0;

    case (state_q)
      S_IDLE: begin
        if_req_ready_o = win_if;
        d_req_ready_o  = win_d;
        if (win_if) begin
          addr_d  = if_req_addr_i[ADDR_W+1:2];
          we_d    = 1'b0;
          wdata_d = '0;
          wstrb_d = '0;
          owner_d = OWN_FETCH;
          last_d  = OWN_FETCH;
          state_d = S_ISSUE;
        end else if (win_d) begin
          addr_d  = d_req_addr_i[ADDR_W+1:2];
          we_d    = d_req_we_i;
          wdata_d = d_req_wdata_i;
          wstrb_d = d_req_wstrb_i;
          owner_d = OWN_DATA;
          last_d  = OWN_DATA;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en_o    = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_wstrb_o = wstrb_q;
        if (MEM_LATENCY == 1) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // Stores are acknowledged with zero data; reads forward the memory word.
        rsp_data = we_q ? 32'h0 : mem_rdata_i;
        if (owner_q == OWN_DATA) begin
          d_rsp_valid_o = 1'b1;
          d_rsp_data_o  = rsp_data;
        end else begin
          if_rsp_valid_o = 1'b1;
          if_rsp_data_o  = rsp_data;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire
